debounce_sync: RTL and testbench
================================

# debounce_sync

Input conditioning stage that sits directly upstream of the `dff` storage cell and drives its `d` input. It synchronises a raw, bouncy, asynchronous level (push-button or switch) into the `clk` domain. It then filters the level with a counter/FSM debouncer and presents a clean level `q`/`qbar` plus optional single-cycle edge pulses. Downstream flops may consume `q` directly, with no further synchronisation.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive qualified samples that must disagree with `q` before `q` flips. Legal range is 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the settle counter.
- `RESET_VAL`, default 1'b0: value of `q` and of both synchroniser flops while in reset.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `din`, input, 1: raw asynchronous level, which may bounce.
- `en`, input, 1: sample-qualify tick. Tie it to 1 to sample every cycle, or drive it from a prescaler for slow debounce.
- `q`, output, 1: debounced level (registered).
- `qbar`, output, 1: always equal to `~q` (registered).
- `rise`, output, 1: one-cycle pulse when `q` goes 0->1 (registered).
- `fall`, output, 1: one-cycle pulse when `q` goes 1->0 (registered).
- `busy`, output, 1: high while a candidate change is settling (registered).

## Operation
- **Synchroniser:** two flops `s1 <= din` and `s2 <= s1`. The debouncer sees only `s2`.
- **FSM:** states IDLE and SETTLE; counter `cnt` is CNT_W bits. Priority order at each edge:
  1. If `rst`: `s1 = s2 = q = RESET_VAL`, `qbar = ~RESET_VAL`, `cnt = 0`, state IDLE, `rise = fall = busy = 0`. Reset overrides every other condition, including a completing sample.
  2. Else if `s2 == q`: `cnt <= 0`, state IDLE. This abort applies regardless of `en`.
  3. Else if `en && cnt == STABLE_CYCLES-1`: `q <= ~q`, `qbar <= q`, `cnt <= 0`, state IDLE.
     - `rise <= ~q` and `fall <= q` for that one cycle.
  4. Else if `en`: `cnt <= cnt + 1`, state SETTLE.
  5. Else: hold `cnt` and state.
- `rise` and `fall` are 0 in every cycle not covered by case 3. They are never high together.
- `busy` equals (state == SETTLE).
- **Counter wrap:** `cnt` never exceeds STABLE_CYCLES-1, so it cannot wrap. STABLE_CYCLES=1 flips `q` on the first qualified disagreeing sample.
- **Bounce:** any return of `s2` to `q`, even for a single cycle, discards all accumulated count.
- **Reset with `din` ≠ RESET_VAL:** after `rst` drops, a normal debounce runs and emits the corresponding edge pulse.

## Timing
- **Latency:** `din` steady and `en` = 1. Counting edges from the first edge at which `din` has its new value, `q` flips STABLE_CYCLES+2 edges later (2 edges of synchroniser, then STABLE_CYCLES samples). With the default of 4, that is 6 edges.
- **Pulse alignment:** `rise`/`fall` assert on the same edge that `q` changes and deassert on the next edge.
- **`busy` window:** with `en` = 1, `busy` rises 3 edges after the `din` change and falls on the edge where `q` flips.
- **`en` gaps:** cycles without `en` extend latency but do not reset `cnt` unless `s2 == q`.
- **Outputs:** all outputs are registered; there is no combinational path from `din`, `en` or `rst` to any output.

## Configuration
- `DEBOUNCE_EDGE_EN`:
  - **Defined:** `rise`/`fall` are generated as described above.
  - **Undefined:** the `rise`/`fall` ports remain but are driven constant 0, and their edge-pulse logic is removed. `q`, `qbar` and `busy` behave identically in both builds.

## Test plan
All scenarios use STABLE_CYCLES=4 and RESET_VAL=0.
- **Reset:** `rst`=1 for 2 cycles with `din`=1 -> `q`=0, `qbar`=1, `rise`=`fall`=`busy`=0. After `rst` drops, `q`=1 and `rise` pulses 6 edges later.
- **Clean rise/fall:** `en`=1; `din` 0->1 held -> `q`=1 at edge 6 with `rise` high for exactly that cycle. Later `din` 1->0 -> `q`=0 at edge 6 with a single `fall` pulse.
- **Bounce reject:** `din` high for 3 cycles, low for 1, high for 3, then low -> `q` stays 0, `rise` never asserts, `busy` returns to 0.
- **`en` gating:** `en` high every 3rd cycle, `din` 0->1 held -> `q` flips on the 4th qualified sample after `s2`=1, and `cnt` holds through the non-`en` cycles.
- **Reset mid-settle:** assert `rst` when `cnt`=2 -> `cnt`=0, `q`=0, no pulse. After release with `din`=1, the full 6-edge latency is required again.
- **Macro off:** rerun the clean rise/fall scenario without `DEBOUNCE_EDGE_EN` -> `rise`=`fall`=0 throughout, and `q`/`qbar`/`busy` match the macro-on run cycle-for-cycle.

Source files
------------

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus counter/FSM debouncer producing a clean q/qbar level.
// Optional rise/fall edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_sync #(
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_W         = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic q,
    output logic qbar,
    output logic rise,
    output logic fall,
    output logic busy
);
    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= RESET_VAL;
            s2    <= RESET_VAL;
            q     <= RESET_VAL;
            qbar  <= ~RESET_VAL;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            rise  <= 1'b0;
            fall  <= 1'b0;
`endif
        end else begin
            s1 <= din;
            s2 <= s1;
`ifdef DEBOUNCE_EDGE_EN
            rise <= 1'b0;
            fall <= 1'b0;
`endif
            // A single sample agreeing with q throws away all accumulated count.
            if (s2 == q) begin
                cnt   <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else if (en && cnt == LAST) begin
                q     <= ~q;
                qbar  <= q;
                cnt   <= '0;
                state <= IDLE;
                busy  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
                rise  <= ~q;
                fall  <= q;
`endif
            end else if (en) begin
                cnt   <= cnt + 1'b1;
                state <= SETTLE;
                busy  <= 1'b1;
            end
        end
    end

`ifndef DEBOUNCE_EDGE_EN
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench: a sample-count reference model pushes expected outputs per edge,
// a negedge monitor pops and compares them against the debouncer.
module tb_debounce_sync;
    localparam int   SC = 4;
    localparam logic RV = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, din, en;
    logic q, qbar, rise, fall, busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    debounce_sync #(.STABLE_CYCLES(SC), .CNT_W(8), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en),
        .q(q), .qbar(qbar), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    // expected {q, qbar, rise, fall, busy} after each edge
    logic [4:0] exp_q[$];

    // Reference model: din reaches the filter two edges late; q flips once SC
    // qualified samples in a row disagree with it.
    logic dq[$];
    logic m_q;
    int   run;
    bit   armed = 1'b0;

    always @(posedge clk) begin
        logic s2v, r, f;
        cycle++;
        r = 1'b0;
        f = 1'b0;
        if (rst) begin
            dq.delete();
            dq.push_back(RV);
            dq.push_back(RV);
            m_q   = RV;
            run   = 0;
            armed = 1'b1;
            exp_q.push_back({RV, ~RV, 3'b000});
        end else if (armed) begin
            s2v = dq[0];
            void'(dq.pop_front());
            dq.push_back(din);
            if (s2v == m_q) begin
                run = 0;
            end else if (en) begin
                run++;
                if (run == SC) begin
                    r   = !m_q;
                    f   = m_q;
                    m_q = !m_q;
                    run = 0;
                end
            end
            exp_q.push_back({m_q, !m_q, r & EDGE_ON, f & EDGE_ON, run > 0});
        end
    end

    always @(negedge clk) begin
        logic [4:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {q, qbar, rise, fall, busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d {q,qbar,rise,fall,busy} got %b expected %b",
                         cycle, a, e);
            end
        end
    end

    task automatic drive(input logic d, input logic e, input logic r, input int n);
        din = d;
        en  = e;
        rst = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        int mode;
        logic d;
        // reset with din high, then the debounce must still run afterwards
        drive(1'b1, 1'b1, 1'b1, 2);
        drive(1'b1, 1'b1, 1'b0, 10);
        // clean fall then clean rise/fall
        drive(1'b0, 1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b0, 10);
        // bounce reject
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 10);
        // en every third cycle
        for (int i = 0; i < 24; i++) drive(1'b1, (i % 3) == 0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 10);
        // reset while settling, then full latency again
        drive(1'b1, 1'b1, 1'b0, 4);
        drive(1'b1, 1'b1, 1'b1, 1);
        drive(1'b1, 1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b0, 10);
        // randomized levels, en gaps and sparse resets
        for (int blk = 0; blk < 500; blk++) begin
            d    = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 9);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < len; i++)
                drive(d, (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1,
                      $urandom_range(0, 299) == 0, 1);
        end
        drive(din, 1'b1, 1'b0, 3);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
